change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_if.sv | 29 ++
 rtl/change_dispenser.sv | 130 +++++++++++++
 tb/tb_change_dispenser.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the change dispenser and its controller/ejector.
// master drives requests, refills and coin_ack; slave is the dispenser.
interface change_dispenser_if;
  logic        start;
  logic [15:0] amount;
  logic        load;
  logic [1:0]  load_coin;
  logic [7:0]  load_count;
  logic        coin_ack;
  logic [1:0]  coins_out;
  logic        coin_valid;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [15:0] remaining;
  logic [7:0]  inv5;
  logic [7:0]  inv10;
  logic [7:0]  inv25;

  modport master (
    output start, amount, load, load_coin, load_count, coin_ack,
    input  coins_out, coin_valid, busy, done, status, remaining, inv5, inv10, inv25
  );

  modport slave (
    input  start, amount, load, load_coin, load_count, coin_ack,
    output coins_out, coin_valid, busy, done, status, remaining, inv5, inv10, inv25
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: picks 25c/10c/5c from a refillable inventory
// and presents one coin at a time to an ejector with a valid/ack handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting; accepts refill (load) or a dispense request (start)
// S_SELECT | choose the largest coin that fits and is in stock
// S_ISSUE  | coin presented on coins_out until coin_ack
// S_DONE   | one-cycle done pulse, back to S_IDLE
module change_dispenser (
  input logic              clk,
  input logic              rst,
  change_dispenser_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;
  localparam logic [1:0] COIN_25 = 2'b11;

  localparam logic [1:0] ST_BAD_AMOUNT = 2'b00;
  localparam logic [1:0] ST_SHORT      = 2'b01;
  localparam logic [1:0] ST_PROCESSING = 2'b10;
  localparam logic [1:0] ST_COMPLETE   = 2'b11;

  logic [1:0]  state;
  logic [1:0]  coin_q;
  logic [1:0]  status_q;
  logic [15:0] remaining_q;
  logic [7:0]  inv5_q;
  logic [7:0]  inv10_q;
  logic [7:0]  inv25_q;
  logic [15:0] coin_val;
  logic        bad_amount;

  assign bad_amount = (bus.amount % 16'd5) != 16'd0;

  always_comb begin
    coin_val = 16'd0;
    case (coin_q)
      COIN_5:  coin_val = 16'd5;
      COIN_10: coin_val = 16'd10;
      COIN_25: coin_val = 16'd25;
      default: coin_val = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      coin_q      <= 2'b00;
      status_q    <= ST_COMPLETE;
      remaining_q <= 16'd0;
      inv5_q      <= 8'd0;
      inv10_q     <= 8'd0;
      inv25_q     <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // refill wins over a simultaneous start
          if (bus.load) begin
            case (bus.load_coin)
              COIN_5:  inv5_q  <= bus.load_count;
              COIN_10: inv10_q <= bus.load_count;
              COIN_25: inv25_q <= bus.load_count;
              default: ;
            endcase
          end else if (bus.start) begin
            remaining_q <= bus.amount;
            if (bad_amount) begin
              status_q <= ST_BAD_AMOUNT;
              state    <= S_DONE;
            end else begin
              status_q <= ST_PROCESSING;
              state    <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (remaining_q == 16'd0) begin
            status_q <= ST_COMPLETE;
            state    <= S_DONE;
          end else if (remaining_q >= 16'd25 && inv25_q != 8'd0) begin
            coin_q <= COIN_25;
            state  <= S_ISSUE;
          end else if (remaining_q >= 16'd10 && inv10_q != 8'd0) begin
            coin_q <= COIN_10;
            state  <= S_ISSUE;
          end else if (remaining_q >= 16'd5 && inv5_q != 8'd0) begin
            coin_q <= COIN_5;
            state  <= S_ISSUE;
          end else begin
            status_q <= ST_SHORT;
            state    <= S_DONE;
          end
        end
        S_ISSUE: begin
          if (bus.coin_ack) begin
            case (coin_q)
              COIN_5:  inv5_q  <= inv5_q - 8'd1;
              COIN_10: inv10_q <= inv10_q - 8'd1;
              COIN_25: inv25_q <= inv25_q - 8'd1;
              default: ;
            endcase
            remaining_q <= remaining_q - coin_val;
            state       <= S_SELECT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // handshake outputs decode straight from state so reset drops them at once
  assign bus.coin_valid = (state == S_ISSUE);
  assign bus.coins_out  = (state == S_ISSUE) ? coin_q : 2'b00;
  assign bus.busy       = (state == S_SELECT) || (state == S_ISSUE);
  assign bus.done       = (state == S_DONE);
  assign bus.status     = status_q;
  assign bus.remaining  = remaining_q;
  assign bus.inv5       = inv5_q;
  assign bus.inv10      = inv10_q;
  assign bus.inv25      = inv25_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy reference model queues the
// expected coins per request and each presented coin is popped and compared.
module tb_change_dispenser;

  logic clk;
  logic rst;
  change_dispenser_if b ();

  change_dispenser dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0]  exp_q[$];
  logic [1:0]  exp_status;
  logic [15:0] exp_rem;
  logic [7:0]  m5, m10, m25;

  function automatic void model_txn(input logic [15:0] amt);
    int r;
    r = int'(amt);
    if ((amt % 16'd5) != 16'd0) begin
      exp_status = 2'b00;
      exp_rem    = amt;
      return;
    end
    while (1) begin
      if (r >= 25 && m25 > 0) begin exp_q.push_back(2'b11); m25--; r -= 25; end
      else if (r >= 10 && m10 > 0) begin exp_q.push_back(2'b10); m10--; r -= 10; end
      else if (r >= 5 && m5 > 0) begin exp_q.push_back(2'b01); m5--; r -= 5; end
      else break;
    end
    exp_status = (r == 0) ? 2'b11 : 2'b01;
    exp_rem    = 16'(r);
  endfunction

  task automatic load_inv(input logic [1:0] coin, input logic [7:0] cnt);
    @(negedge clk);
    b.load = 1'b1; b.load_coin = coin; b.load_count = cnt;
    @(negedge clk);
    b.load = 1'b0;
    case (coin)
      2'b01: m5 = cnt;
      2'b10: m10 = cnt;
      2'b11: m25 = cnt;
      default: ;
    endcase
  endtask

  // Runs one request; coins are popped from the scoreboard as they appear.
  task automatic run_txn(input logic [15:0] amt, input int ack_wait, input bit load_in_issue,
                         output bit stable, output bit inv_still);
    int n_done, first_valid, done_c, stall, c;
    bit fin;
    logic [1:0] held, e;
    logic [7:0] i5, i10, i25;
    stable = 1; inv_still = 1; n_done = 0; first_valid = -1; done_c = -1; stall = 0; fin = 0;
    held = 2'b00; i5 = 8'd0; i10 = 8'd0; i25 = 8'd0;
    model_txn(amt);
    @(negedge clk);
    b.start = 1'b1; b.amount = amt; b.coin_ack = (ack_wait == 0);
    @(negedge clk);
    b.start = 1'b0;
    c = 1;
    while (c < 300 && !fin) begin
      if (b.done) begin n_done++; done_c = c; fin = 1; end
      if (b.coin_valid) begin
        if (first_valid < 0) begin
          first_valid = c;
          total++;
          if (b.status !== 2'b10 || b.busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_status amt=%0d got status=%b busy=%b want 10/1", amt, b.status, b.busy);
          end
        end
        if (stall == 0) begin
          held = b.coins_out; i5 = b.inv5; i10 = b.inv10; i25 = b.inv25;
        end else begin
          if (b.coins_out !== held) stable = 0;
          if (b.inv5 !== i5 || b.inv10 !== i10 || b.inv25 !== i25) inv_still = 0;
        end
        if (stall < ack_wait) begin
          b.coin_ack = 1'b0; stall++;
          if (load_in_issue) begin b.load = 1'b1; b.load_coin = 2'b11; b.load_count = 8'd99; end
        end else begin
          b.coin_ack = 1'b1; b.load = 1'b0; stall = 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL coin_extra amt=%0d got coin=%b want none", amt, b.coins_out);
          end else begin
            e = exp_q.pop_front();
            if (b.coins_out !== e) begin
              bad++;
              $display("FAIL coin amt=%0d got coin=%b want %b", amt, b.coins_out, e);
            end
          end
        end
      end else begin
        b.coin_ack = 1'b1; b.load = 1'b0;
      end
      @(negedge clk); c++;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout amt=%0d got no done want done", amt);
    end
    for (int k = 0; k < 3; k++) begin
      if (b.done) n_done++;
      @(negedge clk);
    end
    total++;
    if (n_done != 1) begin bad++; $display("FAIL done_count amt=%0d got %0d want 1", amt, n_done); end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL coin_missing amt=%0d got %0d unsent want 0", amt, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (b.status !== exp_status) begin bad++; $display("FAIL status amt=%0d got %b want %b", amt, b.status, exp_status); end
    total++;
    if (b.remaining !== exp_rem) begin bad++; $display("FAIL remaining amt=%0d got %0d want %0d", amt, b.remaining, exp_rem); end
    total++;
    if (b.inv5 !== m5 || b.inv10 !== m10 || b.inv25 !== m25) begin
      bad++;
      $display("FAIL inventory amt=%0d got %0d/%0d/%0d want %0d/%0d/%0d", amt, b.inv5, b.inv10, b.inv25, m5, m10, m25);
    end
    if (first_valid >= 0) begin
      total++;
      if (first_valid != 2) begin bad++; $display("FAIL first_valid amt=%0d got %0d want 2", amt, first_valid); end
    end
    if (exp_status == 2'b00) begin
      total++;
      if (done_c != 1 || first_valid != -1) begin
        bad++; $display("FAIL bad_amount_timing amt=%0d got done_c=%0d valid_c=%0d want 1/-1", amt, done_c, first_valid);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (b.coin_valid !== 1'b0 || b.coins_out !== 2'b00 || b.busy !== 1'b0 || b.done !== 1'b0 ||
        b.status !== 2'b11 || b.remaining !== 16'd0 || b.inv5 !== 8'd0 || b.inv10 !== 8'd0 || b.inv25 !== 8'd0) begin
      bad++;
      $display("FAIL %s got v=%b c=%b busy=%b done=%b st=%b rem=%0d inv=%0d/%0d/%0d want reset values",
               tag, b.coin_valid, b.coins_out, b.busy, b.done, b.status, b.remaining, b.inv5, b.inv10, b.inv25);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b.start = 1'b0; b.amount = 16'd0; b.load = 1'b0; b.load_coin = 2'b00; b.load_count = 8'd0; b.coin_ack = 1'b0;
    m5 = 0; m10 = 0; m25 = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b1;
  endtask

  task automatic test_greedy();
    bit s, iv;
    load_inv(2'b01, 8'd10); load_inv(2'b10, 8'd10); load_inv(2'b11, 8'd10);
    load_inv(2'b00, 8'd55);
    run_txn(16'd65, 0, 0, s, iv);
    total++;
    if (b.inv5 !== 8'd9 || b.inv10 !== 8'd9 || b.inv25 !== 8'd8) begin
      bad++; $display("FAIL greedy_inv got %0d/%0d/%0d want 9/9/8", b.inv5, b.inv10, b.inv25);
    end
  endtask

  task automatic test_sparse();
    bit s, iv;
    load_inv(2'b11, 8'd1); load_inv(2'b10, 8'd0); load_inv(2'b01, 8'd2);
    run_txn(16'd40, 0, 0, s, iv);
  endtask

  task automatic test_short();
    bit s, iv;
    load_inv(2'b11, 8'd0); load_inv(2'b10, 8'd1); load_inv(2'b01, 8'd0);
    run_txn(16'd25, 0, 0, s, iv);
  endtask

  task automatic test_bad_amount();
    bit s, iv;
    run_txn(16'd37, 0, 0, s, iv);
  endtask

  task automatic test_ack_stall();
    bit s, iv;
    load_inv(2'b01, 8'd10); load_inv(2'b10, 8'd10); load_inv(2'b11, 8'd10);
    run_txn(16'd30, 4, 1, s, iv);
    total++;
    if (!s) begin bad++; $display("FAIL stall_stable got unstable coins_out want stable"); end
    total++;
    if (!iv) begin bad++; $display("FAIL stall_inventory got change before ack want none"); end
  endtask

  task automatic test_back_to_back();
    bit s, iv;
    run_txn(16'd0, 0, 0, s, iv);
    run_txn(16'd15, 0, 0, s, iv);
    run_txn(16'd5, 1, 0, s, iv);
  endtask

  task automatic test_reset_issue();
    int seen, n_done;
    bit s, iv;
    load_inv(2'b11, 8'd5);
    seen = 0; n_done = 0;
    @(negedge clk);
    b.start = 1'b1; b.amount = 16'd50; b.coin_ack = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      if (b.coin_valid) seen++;
      if (seen < 2) @(negedge clk);
    end
    total++;
    if (seen != 2) begin bad++; $display("FAIL second_coin got %0d coins want 2", seen); end
    b.coin_ack = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_values("reset_in_issue");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (b.done) n_done++;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (b.done) n_done++;
    end
    total++;
    if (n_done != 0) begin bad++; $display("FAIL reset_done got %0d pulses want 0", n_done); end
    m5 = 0; m10 = 0; m25 = 0; exp_q.delete();
    check_reset_values("after_reset_release");
    run_txn(16'd37, 0, 0, s, iv);
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_sparse();
    test_short();
    test_bad_amount();
    test_ack_stall();
    test_back_to_back();
    test_reset_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
